frogger_game_fsm: RTL and testbench
===================================

# frogger_game_fsm

Game-state controller sitting directly downstream of the frog position/draw stage. It consumes the frog tile position and per-pixel draw flags, and detects car collisions and goal-row arrivals. It maintains score and lives and drives the game-active enable and a respawn pulse back to the frog controller. It also feeds score and lives to the HUD/7-segment stage.

## Interface
- START_LIVES, 3, lives loaded at game start (1..3)
- MAX_SCORE, 99, score saturation value (≤127)
- GOAL_ROW, 0, frog tile row that counts as a crossing
- DEATH_HOLD_CYCLES, 12_500_000, freeze length after a hit (0.5 s at 25 MHz); ≥2
- i_Clk  in  1  system clock; single clock domain
- i_Reset  in  1  synchronous, active-high reset
- i_Start  in  1  start button level, already debounced; rising edge used
- i_Frame_Tick  in  1  one-cycle pulse at start of each frame
- i_Frogger_X  in  6  frog tile column (0..19)
- i_Frogger_Y  in  6  frog tile row (0..14)
- i_Draw_Frogger  in  1  current pixel belongs to frog
- i_Draw_Car  in  1  current pixel belongs to any car
- o_Game_Active  out  1  movement/traffic enable
- o_Respawn  out  1  one-cycle pulse: frog controller returns frog to start tile
- o_Score  out  7  crossings completed, saturating
- o_Lives  out  2  remaining lives
- o_Game_Over  out  1  high while in GAME_OVER
- o_State  out  3  current state encoding, for debug/HUD

## Operation
- States: IDLE=0, PLAY=1, HIT=2, GAME_OVER=3.
- Start edge: r_Start registers i_Start. An edge is i_Start=1 and r_Start=0.
- IDLE: outputs inactive.
  - Start edge → PLAY, score←0, lives←START_LIVES, o_Respawn pulse, grace←1.
- PLAY: o_Game_Active=1.
  - Grace flag blocks hit/goal detection until the next i_Frame_Tick clears it. This covers the frog position lag after a respawn.
  - With grace=0:
    - Hit = i_Draw_Frogger & i_Draw_Car in the same cycle.
    - Goal = i_Frogger_Y == GOAL_ROW.
  - Hit → HIT: lives←lives−1, hold counter←0.
  - Goal (no hit): score←min(score+1, MAX_SCORE), o_Respawn pulse, grace←1, stay in PLAY.
  - Hit and goal in the same cycle: hit wins, no score change.
  - Start edge is ignored in PLAY.
- HIT: o_Game_Active=0.
  - If lives==0 on entry → GAME_OVER on the next cycle, no respawn.
  - Otherwise the counter increments each cycle. At DEATH_HOLD_CYCLES−1: o_Respawn pulse, grace←1, counter←0, → PLAY.
- GAME_OVER: o_Game_Over=1, o_Game_Active=0. Score and lives are held.
  - Start edge → same actions as a start from IDLE.
- Arithmetic:
  - Lives never wrap below 0; a decrement at 0 is impossible by construction.
  - Score saturates and never wraps.
  - Hold counter is 24 bits minimum, sized from DEATH_HOLD_CYCLES.

## Timing
- All outputs are registered. Events are sampled on a cycle; state and outputs change on the next rising edge (1-cycle latency).
- Reset values: state=IDLE, o_Game_Active=0, o_Respawn=0, o_Score=0, o_Lives=START_LIVES, o_Game_Over=0, o_State=0, grace=0, counter=0, r_Start=0.
- Reset mid-operation (any state, including mid-hold) returns to these values on the next edge. A pending respawn pulse is dropped.
- o_Respawn is exactly 1 cycle wide and is never asserted in the same cycle as an o_Game_Active 1→0 transition.
- Hit detection is pixel-accurate within a frame: the first overlapping pixel triggers it; later overlaps in HIT are ignored.
- Goal detection fires at most once per respawn, because grace re-arms after each pulse.
- A hit-to-respawn cycle lasts DEATH_HOLD_CYCLES cycles in HIT, plus 1 cycle of entry latency.
- Timing of i_Frame_Tick is independent of state. A tick arriving in the same cycle as a respawn pulse does not clear that new grace; grace clears on the following tick.

## Test plan
- Reset, then 1-cycle i_Start pulse → next edge: o_State=1, o_Game_Active=1, o_Lives=3, o_Score=0, o_Respawn high for exactly 1 cycle.
- In PLAY after a frame tick, i_Frogger_Y=0 → o_Score=1, one o_Respawn pulse. Y held at 0 without a new frame tick → score stays 1.
- DEATH_HOLD_CYCLES=4: one cycle with i_Draw_Frogger=i_Draw_Car=1 → o_State=2, o_Lives=2, o_Game_Active=0. After 4 cycles, o_Respawn pulses and o_State=1.
- Three hits separated by frame ticks → o_Lives=0, o_State=3, o_Game_Over=1. Start edge → o_Lives=3, o_Score=0, o_State=1.
- Hit and Y=0 in the same cycle → HIT entered, o_Score unchanged. Score preloaded to 99 plus a goal → o_Score stays 99.
- i_Reset asserted at hold cycle 2 of HIT → next edge: o_State=0, o_Lives=3, o_Score=0, and no o_Respawn pulse follows.

Source files
------------

// File: rtl/frogger_game_fsm.sv
// Frogger game-state controller: collision/goal detection, score, lives,
// game-active enable and frog respawn pulse.
module frogger_game_fsm #(
    parameter int START_LIVES       = 3,
    parameter int MAX_SCORE         = 99,
    parameter int GOAL_ROW          = 0,
    parameter int DEATH_HOLD_CYCLES = 12_500_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic       i_Frame_Tick,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    input  logic       i_Draw_Frogger,
    input  logic       i_Draw_Car,
    output logic       o_Game_Active,
    output logic       o_Respawn,
    output logic [6:0] o_Score,
    output logic [1:0] o_Lives,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    localparam int HOLD_BITS = $clog2(DEATH_HOLD_CYCLES);
    localparam int CW = (HOLD_BITS > 24) ? HOLD_BITS : 24;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_HIT  = 3'd2,
        S_OVER = 3'd3
    } state_t;

    state_t        state, state_n;
    logic [6:0]    score, score_n;
    logic [1:0]    lives, lives_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          grace, grace_n;
    logic          r_Start;
    logic          respawn_n;
    logic          start_edge;
    logic          hit;
    logic          goal;

    // Collision is decided from the draw flags alone, so the column is unused.
    logic unused_x;
    assign unused_x = ^i_Frogger_X;

    assign start_edge = i_Start & ~r_Start;
    assign hit  = i_Draw_Frogger & i_Draw_Car & ~grace;
    assign goal = (i_Frogger_Y == 6'(GOAL_ROW)) & ~grace;

    always_comb begin
        state_n   = state;
        score_n   = score;
        lives_n   = lives;
        cnt_n     = cnt;
        grace_n   = grace;
        respawn_n = 1'b0;
        if (i_Frame_Tick)
            grace_n = 1'b0;
        unique case (state)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    state_n   = S_PLAY;
                    score_n   = '0;
                    lives_n   = 2'(START_LIVES);
                    cnt_n     = '0;
                    respawn_n = 1'b1;
                    grace_n   = 1'b1;
                end
            end
            S_PLAY: begin
                if (hit) begin
                    state_n = S_HIT;
                    lives_n = lives - 2'd1;
                    cnt_n   = '0;
                end else if (goal) begin
                    if (score < 7'(MAX_SCORE))
                        score_n = score + 7'd1;
                    respawn_n = 1'b1;
                    grace_n   = 1'b1;
                end
            end
            S_HIT: begin
                if (lives == 2'd0) begin
                    state_n = S_OVER;
                end else if (cnt == CW'(DEATH_HOLD_CYCLES - 1)) begin
                    state_n   = S_PLAY;
                    cnt_n     = '0;
                    respawn_n = 1'b1;
                    grace_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= S_IDLE;
            score         <= '0;
            lives         <= 2'(START_LIVES);
            cnt           <= '0;
            grace         <= 1'b0;
            r_Start       <= 1'b0;
            o_Respawn     <= 1'b0;
            o_Game_Active <= 1'b0;
            o_Game_Over   <= 1'b0;
        end else begin
            state         <= state_n;
            score         <= score_n;
            lives         <= lives_n;
            cnt           <= cnt_n;
            grace         <= grace_n;
            r_Start       <= i_Start;
            o_Respawn     <= respawn_n;
            o_Game_Active <= (state_n == S_PLAY);
            o_Game_Over   <= (state_n == S_OVER);
        end
    end

    assign o_Score = score;
    assign o_Lives = lives;
    assign o_State = state;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Scoreboard bench for frogger_game_fsm: directed scenarios plus random
// traffic, predicted by a game-rules model and checked by a monitor.
module tb_frogger_game_fsm;

    localparam int LIVES0 = 3;
    localparam int MAXSC  = 5;
    localparam int GOAL   = 0;
    localparam int HOLD   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [5:0] fx = '0;
    logic [5:0] fy = 6'd5;
    logic       dfrog = 1'b0;
    logic       dcar = 1'b0;
    logic       active, respawn, over;
    logic [6:0] score;
    logic [1:0] lives;
    logic [2:0] st;

    frogger_game_fsm #(
        .START_LIVES(LIVES0),
        .MAX_SCORE(MAXSC),
        .GOAL_ROW(GOAL),
        .DEATH_HOLD_CYCLES(HOLD)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Start(start),
        .i_Frame_Tick(tick),
        .i_Frogger_X(fx),
        .i_Frogger_Y(fy),
        .i_Draw_Frogger(dfrog),
        .i_Draw_Car(dcar),
        .o_Game_Active(active),
        .o_Respawn(respawn),
        .o_Score(score),
        .o_Lives(lives),
        .o_Game_Over(over),
        .o_State(st)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       act;
        logic       rsp;
        logic [6:0] sc;
        logic [1:0] lv;
        logic       ov;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Game-rules model: phase names, remaining freeze time, plain integers.
    int m_phase;
    int m_score;
    int m_lives;
    int m_freeze_left;
    bit m_shield;
    bit m_prev_btn;

    task automatic model_step(input bit r, input bit s, input bit t,
                              input int y, input bit f, input bit c,
                              output obs_t o);
        bit pulse;
        bit shield_next;
        pulse = 0;
        if (r) begin
            m_phase = 0;
            m_score = 0;
            m_lives = LIVES0;
            m_freeze_left = 0;
            m_shield = 0;
            m_prev_btn = 0;
        end else begin
            shield_next = m_shield && !t;
            if (m_phase == 0 || m_phase == 3) begin
                if (s && !m_prev_btn) begin
                    m_phase = 1;
                    m_score = 0;
                    m_lives = LIVES0;
                    pulse = 1;
                    shield_next = 1;
                end
            end else if (m_phase == 1) begin
                if (!m_shield && f && c) begin
                    m_lives = m_lives - 1;
                    m_phase = 2;
                    m_freeze_left = HOLD;
                end else if (!m_shield && y == GOAL) begin
                    m_score = (m_score + 1 > MAXSC) ? MAXSC : m_score + 1;
                    pulse = 1;
                    shield_next = 1;
                end
            end else begin
                if (m_lives == 0) begin
                    m_phase = 3;
                end else begin
                    m_freeze_left = m_freeze_left - 1;
                    if (m_freeze_left == 0) begin
                        m_phase = 1;
                        pulse = 1;
                        shield_next = 1;
                    end
                end
            end
            m_shield = shield_next;
            m_prev_btn = s;
        end
        o.st  = 3'(m_phase);
        o.act = (m_phase == 1);
        o.rsp = pulse;
        o.sc  = 7'(m_score);
        o.lv  = 2'(m_lives);
        o.ov  = (m_phase == 3);
    endtask

    task automatic cyc(input bit r, input bit s, input bit t,
                       input int y, input bit f, input bit c);
        obs_t e;
        @(negedge clk);
        rst = r;
        start = s;
        tick = t;
        fy = 6'(y);
        fx = 6'($urandom_range(0, 19));
        dfrog = f;
        dcar = c;
        model_step(r, s, t, y, f, c, e);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = '{st, active, respawn, score, lives, over};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sb @%0t: got st%0d a%0b r%0b s%0d l%0d o%0b want st%0d a%0b r%0b s%0d l%0d o%0b",
                         $time, a.st, a.act, a.rsp, a.sc, a.lv, a.ov,
                         e.st, e.act, e.rsp, e.sc, e.lv, e.ov);
            end
        end
    end

    task automatic do_hit_and_recover();
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 5, 1, 1);
        for (int i = 0; i < HOLD; i++)
            cyc(0, 0, 0, 5, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 5, 0, 0);
        cyc(1, 0, 0, 5, 0, 0);
        chk("rst_state", st, 0);
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_active", active, 0);
        chk("rst_respawn", respawn, 0);

        cyc(0, 1, 0, 5, 0, 0);
        chk("start_state", st, 1);
        chk("start_active", active, 1);
        chk("start_lives", lives, 3);
        chk("start_respawn", respawn, 1);
        cyc(0, 1, 0, 5, 0, 0);
        chk("respawn_width", respawn, 0);

        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("goal_score", score, 1);
        chk("goal_respawn", respawn, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("goal_once", score, 1);
        chk("goal_rsp_once", respawn, 0);

        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("hitgoal_state", st, 2);
        chk("hitgoal_score", score, 1);
        chk("hit_lives", lives, 2);
        chk("hit_active", active, 0);
        for (int i = 0; i < HOLD - 1; i++) begin
            cyc(0, 0, 0, 5, 0, 0);
            chk("hold_state", st, 2);
        end
        cyc(0, 0, 0, 5, 0, 0);
        chk("hold_end_state", st, 1);
        chk("hold_end_rsp", respawn, 1);

        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 5, 1, 1);
        cyc(0, 0, 0, 5, 0, 0);
        cyc(0, 0, 0, 5, 0, 0);
        cyc(1, 0, 0, 5, 0, 0);
        chk("midrst_state", st, 0);
        chk("midrst_lives", lives, 3);
        chk("midrst_score", score, 0);
        for (int i = 0; i < HOLD + 2; i++) begin
            cyc(0, 0, 0, 5, 0, 0);
            chk("midrst_norsp", respawn, 0);
        end

        cyc(0, 1, 0, 5, 0, 0);
        cyc(0, 0, 0, 5, 0, 0);
        do_hit_and_recover();
        do_hit_and_recover();
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 5, 1, 1);
        chk("last_hit_lives", lives, 0);
        cyc(0, 0, 0, 5, 0, 0);
        chk("over_state", st, 3);
        chk("over_flag", over, 1);
        cyc(0, 0, 0, 5, 0, 0);
        chk("over_hold", st, 3);
        cyc(0, 1, 0, 5, 0, 0);
        chk("restart_lives", lives, 3);
        chk("restart_state", st, 1);
        chk("restart_score", score, 0);

        for (int i = 0; i < MAXSC + 2; i++) begin
            cyc(0, 0, 1, 5, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
        chk("sat_score", score, MAXSC);

        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit s;
            bit t;
            bit f;
            bit c;
            int y;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 2) == 0);
            y = ($urandom_range(0, 4) == 0) ? GOAL : $urandom_range(1, 14);
            if ($urandom_range(0, 399) == 0)
                s = 1;
            cyc(r, s, t, y, f, c);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
